alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width.
REQ-002 clk  input  1  rising-edge clock, sole clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 reqN_valid  input  1  requester N (N=0,1) command valid.
REQ-005 reqN_ready  output  1  command accepted when valid&ready high at clk edge.
REQ-006 reqN_a, reqN_b  input  WIDTH  operands.
REQ-007 reqN_sel  input  4  ALU opcode: 0 AND, 1 OR, 2 NOT, 3 NOR, 4 XOR, 5 NAND, others forwarded unchanged.
REQ-008 reqN_cin  input  1  carry-in.
REQ-009 rspN_valid  output  1  result for requester N available.
REQ-010 rspN_ready  input  1  requester N consumes result.
REQ-011 rspN_y  output  WIDTH  captured ALU result.
REQ-012 rspN_flags  output  4  {Cout, Negative, Zero, Overflow} captured.
REQ-013 alu_a, alu_b  output  WIDTH  registered operands to shared ALU.
REQ-014 alu_sel  output  4;  alu_cin  output  1  registered opcode/carry to ALU.
REQ-015 alu_y  input  WIDTH;  alu_cout, alu_neg, alu_zero, alu_ovf  input  1  combinational ALU outputs.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states IDLE, EXEC, RESP; one command in flight at a time.
REQ-018 IDLE: reqN_ready = 1 only for the granted requester, combinational from reqN_valid and last_grant; both readys 0 in EXEC/RESP.
REQ-019 Grant: only one valid -> that one; both valid -> requester != last_grant (round-robin); none -> no grant.
REQ-020 On accept edge: load alu_a/alu_b/alu_sel/alu_cin from granted request, record owner, update last_grant to owner, IDLE->EXEC.
REQ-021 EXEC lasts exactly one cycle; at its ending edge capture alu_y and flags into owner's rsp registers, EXEC->RESP.
REQ-022 RESP: rsp<owner>_valid = 1, other rsp valid 0; rspN_y/rspN_flags stable until handshake.
REQ-023 On rsp<owner>_valid & rsp<owner>_ready edge: RESP->IDLE; next accept no earlier than following edge.
REQ-024 Latency: accept at edge t0 -> rsp_valid visible after edge t0+1; minimum throughput one command per 3 cycles.
REQ-025 alu_* outputs hold last issued values outside EXEC; no change except at accept edge.
REQ-026 rspN_y/rspN_flags of a requester retain last captured value after its handshake until overwritten by its next capture.
REQ-027 Opcode and cin passed to ALU unmodified; controller does not decode sel; sel 6-15 issued and result returned as-is.
REQ-028 reqN_valid dropped without ready: no effect; request contents sampled only at accept edge.
REQ-029 rspN_ready asserted while rspN_valid low: ignored.

Reset
REQ-030 rst_n low asynchronously forces state IDLE, last_grant=1 (requester 0 wins first tie), all outputs 0: reqN_ready 0 while in reset, rspN_valid 0, rspN_y 0, rspN_flags 0, alu_* 0, busy 0.
REQ-031 Reset during EXEC or RESP discards the in-flight command; no response issued after release.
REQ-032 First accept possible on first clk edge with rst_n high.

Verification
REQ-033 Single: req0 a=0xF0F0F0F0 b=0xFF00FF00 sel=0 -> accept edge t0, rsp0_valid after t0+1, rsp0_y=0xF000F000 per ALU model, rsp1_valid stays 0.
REQ-034 Tie: both valid continuously after reset, rsp readys tied 1 -> grants 0,1,0,1; each rsp routed to correct requester with its own result.
REQ-035 Back-pressure: rsp1_ready held 0 for 10 cycles -> rsp1_valid, rsp1_y stable, busy 1, both reqN_ready 0; release -> IDLE next edge.
REQ-036 Reset mid-op: rst_n low during RESP -> all outputs 0 immediately; after release no rsp_valid without new request.
REQ-037 Opcode passthrough: sel=4'hA, cin=1 -> alu_sel=4'hA, alu_cin=1 during EXEC; alu_* unchanged during RESP/IDLE.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared external ALU.
// One command in flight: IDLE accepts, EXEC waits one cycle for the ALU, RESP holds the result.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_sel,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_sel,
  input  logic             req1_cin,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_y,
  output logic [3:0]       rsp0_flags,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_y,
  output logic [3:0]       rsp1_flags,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout,
  input  logic             alu_neg,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshake: a transfer happens on a rising clk edge where valid and ready are both high.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_sel_q, alu_sel_d;
  logic             alu_cin_q, alu_cin_d;
  logic [WIDTH-1:0] rsp0_y_q, rsp0_y_d;
  logic [WIDTH-1:0] rsp1_y_q, rsp1_y_d;
  logic [3:0]       rsp0_flags_q, rsp0_flags_d;
  logic [3:0]       rsp1_flags_q, rsp1_flags_d;
  logic             grant0, grant1;
  logic             rsp_done;

  // On a tie the requester that did not win last time gets the grant.
  assign grant0 = req0_valid && (!req1_valid || last_grant_q);
  assign grant1 = req1_valid && (!req0_valid || !last_grant_q);
  assign rsp_done = owner_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    alu_cin_d    = alu_cin_q;
    rsp0_y_d     = rsp0_y_q;
    rsp1_y_d     = rsp1_y_q;
    rsp0_flags_d = rsp0_flags_q;
    rsp1_flags_d = rsp1_flags_q;
    case (state_q)
      S_IDLE: begin
        if (grant0 || grant1) begin
          owner_d      = grant1;
          last_grant_d = grant1;
          alu_a_d      = grant1 ? req1_a   : req0_a;
          alu_b_d      = grant1 ? req1_b   : req0_b;
          alu_sel_d    = grant1 ? req1_sel : req0_sel;
          alu_cin_d    = grant1 ? req1_cin : req0_cin;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        if (owner_q) begin
          rsp1_y_d     = alu_y;
          rsp1_flags_d = {alu_cout, alu_neg, alu_zero, alu_ovf};
        end else begin
          rsp0_y_d     = alu_y;
          rsp0_flags_d = {alu_cout, alu_neg, alu_zero, alu_ovf};
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      alu_cin_q    <= 1'b0;
      rsp0_y_q     <= '0;
      rsp1_y_q     <= '0;
      rsp0_flags_q <= '0;
      rsp1_flags_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      alu_cin_q    <= alu_cin_d;
      rsp0_y_q     <= rsp0_y_d;
      rsp1_y_q     <= rsp1_y_d;
      rsp0_flags_q <= rsp0_flags_d;
      rsp1_flags_q <= rsp1_flags_d;
    end
  end

  // Ready is gated by rst_n so both stay low while reset is asserted.
  assign req0_ready = rst_n && (state_q == S_IDLE) && grant0;
  assign req1_ready = rst_n && (state_q == S_IDLE) && grant1;
  assign rsp0_valid = (state_q == S_RESP) && !owner_q;
  assign rsp1_valid = (state_q == S_RESP) && owner_q;
  assign rsp0_y     = rsp0_y_q;
  assign rsp1_y     = rsp1_y_q;
  assign rsp0_flags = rsp0_flags_q;
  assign rsp1_flags = rsp1_flags_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign alu_cin    = alu_cin_q;
  assign busy       = (state_q != S_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on the shared port.
module tb_alu_arbiter;

  localparam int W = 32;

  logic         clk, rst_n;
  logic         req0_valid, req0_ready, req0_cin;
  logic [W-1:0] req0_a, req0_b;
  logic [3:0]   req0_sel;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req1_a, req1_b;
  logic [3:0]   req1_sel;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0] rsp0_y, rsp1_y;
  logic [3:0]   rsp0_flags, rsp1_flags;
  logic [W-1:0] alu_a, alu_b, alu_y;
  logic [3:0]   alu_sel;
  logic         alu_cin, alu_cout, alu_neg, alu_zero, alu_ovf;
  logic         busy;
  logic [1:0]   dbg_state;

  int n_vec = 0;
  int n_err = 0;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sel(req0_sel), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sel(req1_sel), .req1_cin(req1_cin),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_y(rsp0_y), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_y(rsp1_y), .rsp1_flags(rsp1_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_y(alu_y), .alu_cout(alu_cout), .alu_neg(alu_neg), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: logic ops for 0-5, add with carry for the rest.
  always_comb begin
    logic [W:0] sum;
    sum      = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_cin};
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (alu_sel)
      4'd0: alu_y = alu_a & alu_b;
      4'd1: alu_y = alu_a | alu_b;
      4'd2: alu_y = ~alu_a;
      4'd3: alu_y = ~(alu_a | alu_b);
      4'd4: alu_y = alu_a ^ alu_b;
      4'd5: alu_y = ~(alu_a & alu_b);
      default: begin
        alu_y    = sum[W-1:0];
        alu_cout = sum[W];
        alu_ovf  = (alu_a[W-1] == alu_b[W-1]) && (sum[W-1] != alu_a[W-1]);
      end
    endcase
    alu_neg  = alu_y[W-1];
    alu_zero = (alu_y == '0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = '0; req1_cin = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Reset values, with a valid request pending to show ready is held low
    tick();
    req0_valid = 1'b1;
    #1;
    check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_rsp1_y", rsp1_y, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);

    // Single AND command from requester 0
    req0_a = 32'hF0F0_F0F0; req0_b = 32'hFF00_FF00; req0_sel = 4'd0; req0_cin = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("single_req0_ready", {31'd0, req0_ready}, 32'd1);
    check("single_req1_ready", {31'd0, req1_ready}, 32'd0);
    tick();                                   // accept edge t0
    req0_valid = 1'b0;
    check("single_exec_busy", {31'd0, busy}, 32'd1);
    check("single_exec_alu_a", alu_a, 32'hF0F0_F0F0);
    check("single_exec_alu_b", alu_b, 32'hFF00_FF00);
    check("single_exec_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    tick();                                   // t0+1
    check("single_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    check("single_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("single_rsp0_y", rsp0_y, 32'hF000_F000);
    check("single_rsp0_flags", {28'd0, rsp0_flags}, 32'h4);
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    check("single_idle_busy", {31'd0, busy}, 32'd0);
    check("single_idle_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("single_retain_rsp0_y", rsp0_y, 32'hF000_F000);

    // Tie: both requesters valid continuously from reset release
    rst_n = 1'b0;
    #1;
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_sel = 4'd1;
    req1_valid = 1'b1; req1_a = 32'd5; req1_b = 32'd3; req1_sel = 4'd5;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      logic own;
      own = i[0];
      check("tie_req0_ready", {31'd0, req0_ready}, {31'd0, !own});
      check("tie_req1_ready", {31'd0, req1_ready}, {31'd0, own});
      tick();
      check("tie_alu_sel", {28'd0, alu_sel}, own ? 32'd5 : 32'd1);
      tick();
      check("tie_rsp0_valid", {31'd0, rsp0_valid}, {31'd0, !own});
      check("tie_rsp1_valid", {31'd0, rsp1_valid}, {31'd0, own});
      if (own) check("tie_rsp1_y", rsp1_y, 32'hFFFF_FFFE);
      else     check("tie_rsp0_y", rsp0_y, 32'h0000_0007);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("tie_rsp1_flags", {28'd0, rsp1_flags}, 32'h4);

    // Back-pressure on requester 1, with requester 0 waiting
    req1_valid = 1'b1; req1_a = 32'h7FFF_FFFF; req1_b = 32'd1; req1_sel = 4'd6; req1_cin = 1'b0;
    rsp1_ready = 1'b0;
    #1;
    check("bp_req1_ready", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd0; req0_b = 32'd0; req0_sel = 4'd0;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
      check("bp_rsp1_y", rsp1_y, 32'h8000_0000);
      check("bp_busy", {31'd0, busy}, 32'd1);
      check("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
      check("bp_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
      tick();
    end
    check("bp_rsp1_flags", {28'd0, rsp1_flags}, 32'h5);
    rsp1_ready = 1'b1;
    req0_valid = 1'b0;
    tick();
    rsp1_ready = 1'b0;
    check("bp_release_busy", {31'd0, busy}, 32'd0);
    check("bp_release_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);

    // Opcode passthrough: sel 0xA with carry-in
    req0_valid = 1'b1; req0_a = 32'h1234_5678; req0_b = 32'h1111_1111; req0_sel = 4'hA; req0_cin = 1'b1;
    rsp0_ready = 1'b0;
    tick();
    req0_valid = 1'b0;
    check("pass_exec_sel", {28'd0, alu_sel}, 32'hA);
    check("pass_exec_cin", {31'd0, alu_cin}, 32'd1);
    tick();
    check("pass_resp_sel", {28'd0, alu_sel}, 32'hA);
    check("pass_rsp0_y", rsp0_y, 32'h2345_678A);
    check("pass_rsp1_y_retained", rsp1_y, 32'h8000_0000);
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    check("pass_idle_sel", {28'd0, alu_sel}, 32'hA);
    check("pass_idle_alu_a", alu_a, 32'h1234_5678);
    check("pass_idle_cin", {31'd0, alu_cin}, 32'd1);

    // Reset during RESP discards the command
    req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9; req1_sel = 4'd4; req1_cin = 1'b0;
    tick();
    tick();
    check("rmid_rsp1_valid_before", {31'd0, rsp1_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rmid_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("rmid_busy", {31'd0, busy}, 32'd0);
    check("rmid_alu_a", alu_a, 32'd0);
    check("rmid_rsp0_y", rsp0_y, 32'd0);
    check("rmid_req1_ready", {31'd0, req1_ready}, 32'd0);
    req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rpost_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
      check("rpost_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
      check("rpost_busy", {31'd0, busy}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
